cgra_config_sequencer: RTL

Sequences configuration traffic from a single global-controller request stream onto the CGRA interconnect's per-column config buses (12 columns). Decodes the target column from the address, stalls that column around the access, issues a one-cycle read or write strobe, and returns read data captured from the shared `read_config_data` return bus. Sits between the global controller / JTAG config master and the interconnect top.

---
 rtl/cgra_config_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cgra_config_sequencer.sv
// cgra_config_sequencer: serialises global-controller config requests onto
// per-column CGRA config buses. Decodes the column, stalls it around the
// access, issues a one-cycle read/write strobe and returns read data.
// Optional feature macro: CFG_SEQ_BROADCAST_EN (column 0xFF write = all columns).
module cgra_config_sequencer #(
  parameter int unsigned NUM_COLS = 12,
  parameter int unsigned COL_LSB  = 0,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output logic                     err_sticky,
  input  logic [NUM_COLS-1:0]      stall_in,
  output logic [NUM_COLS-1:0]      stall,
  output logic [32*NUM_COLS-1:0]   config_addr,
  output logic [32*NUM_COLS-1:0]   config_data,
  output logic [NUM_COLS-1:0]      config_read,
  output logic [NUM_COLS-1:0]      config_write,
  input  logic [31:0]              read_config_data
);

  localparam int unsigned CW = 8;
  localparam int unsigned LW = 4;
  localparam logic [CW-1:0] NUM_COLS_B = CW'(NUM_COLS);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STALL = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  write_q, write_d;
  logic [NUM_COLS-1:0]   colmask_q, colmask_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [NUM_COLS-1:0]   stall_mask_q, stall_mask_d;
  logic [NUM_COLS-1:0]   cfg_rd_q, cfg_rd_d;
  logic [NUM_COLS-1:0]   cfg_wr_q, cfg_wr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;

  logic [CW-1:0]         req_col_c;
  logic [NUM_COLS-1:0]   req_mask_c;
  logic                  req_legal_c;

  assign req_col_c = req_addr[COL_LSB +: CW];

  // Column decode of the incoming request into a strobe/stall mask
  always_comb begin
    req_mask_c  = '0;
    req_legal_c = 1'b0;
    if (req_col_c < NUM_COLS_B) begin
      req_mask_c  = NUM_COLS'(1) << req_col_c;
      req_legal_c = 1'b1;
    end
`ifdef CFG_SEQ_BROADCAST_EN
    else if ((req_col_c == 8'hFF) && req_write) begin
      req_mask_c  = '1;
      req_legal_c = 1'b1;
    end
`endif
  end

  // Next-state and next-output logic; outputs are precomputed from state_d
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    write_d     = write_q;
    colmask_d   = colmask_q;
    cnt_d       = cnt_q;
    cfg_rd_d    = '0;
    cfg_wr_d    = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          data_d    = req_data;
          write_d   = req_write;
          colmask_d = req_mask_c;
          if (req_legal_c) begin
            state_d = S_STALL;
          end else begin
            err_d = 1'b1;
            if (!req_write) begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
            end
          end
        end
      end
      S_STALL: begin
        state_d = S_ISSUE;
        if (write_q) cfg_wr_d = colmask_q;
        else         cfg_rd_d = colmask_q;
      end
      S_ISSUE: begin
        if (write_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = read_config_data;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    stall_mask_d = ((state_d == S_STALL) || (state_d == S_ISSUE) || (state_d == S_WAIT))
                   ? colmask_d : '0;
    req_ready_d  = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      colmask_q    <= '0;
      cnt_q        <= '0;
      stall_mask_q <= '0;
      cfg_rd_q     <= '0;
      cfg_wr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      write_q      <= write_d;
      colmask_q    <= colmask_d;
      cnt_q        <= cnt_d;
      stall_mask_q <= stall_mask_d;
      cfg_rd_q     <= cfg_rd_d;
      cfg_wr_q     <= cfg_wr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_data     = rsp_data_q;
  assign err_sticky   = err_q;
  assign config_read  = cfg_rd_q;
  assign config_write = cfg_wr_q;
  assign config_addr  = {NUM_COLS{addr_q}};
  assign config_data  = {NUM_COLS{data_q}};
  assign stall        = stall_in | stall_mask_q;

endmodule
